instruction_fetch_unit: RTL and testbench

Upstream stage of the KGP-RISC datapath. It owns the program counter, fetches instruction words from an instruction memory over a request/valid handshake, and holds the fetched word in an instruction register for the datapath. It also produces the link address (PC+4) for the writeback mux. When the datapath reports completion, the unit resolves the branch control and the ALU flags into the next PC.

---
 rtl/kgp_risc_pkg.sv | 27 ++
 rtl/branch_resolver.sv | 43 ++++
 rtl/instruction_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// rtl/kgp_risc_pkg.sv - shared branch codes, halt opcode and fetch FSM encoding for KGP-RISC
package kgp_risc_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_B    = 3'b001;
  localparam logic [2:0] BR_BR   = 3'b010;
  localparam logic [2:0] BR_BLTZ = 3'b011;
  localparam logic [2:0] BR_BZ   = 3'b100;
  localparam logic [2:0] BR_BNZ  = 3'b101;
  localparam logic [2:0] BR_BCY  = 3'b110;
  localparam logic [2:0] BR_BNCY = 3'b111;

  localparam logic [5:0] HALT_OPC = 6'b111111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Word displacement relative to the link address, wrapping modulo 2^32.
  function automatic logic [31:0] rel_target(input logic [31:0] base, input logic [25:0] disp);
    return base + {{4{disp[25]}}, disp, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - combinational next-PC selection from branch code, ALU flags and operands
module branch_resolver
  import kgp_risc_pkg::*;
(
  input  logic [2:0]  i_branch,
  input  logic        i_zero,
  input  logic        i_sign,
  input  logic        i_carry,
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_pda,
  input  logic [31:0] i_rs_val,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);

  logic [31:0] w_rel;
  logic        w_taken;

  assign w_rel = rel_target(i_pc_plus4, i_pda);

  always_comb begin
    w_taken   = 1'b0;
    o_next_pc = i_pc_plus4;
    case (i_branch)
      BR_B:    w_taken = 1'b1;
      BR_BLTZ: w_taken = i_sign;
      BR_BZ:   w_taken = i_zero;
      BR_BNZ:  w_taken = !i_zero;
      BR_BCY:  w_taken = i_carry;
      BR_BNCY: w_taken = !i_carry;
      default: w_taken = 1'b0;
    endcase
    // Register-indirect target drops the byte offset; the flag below reports it.
    if (i_branch == BR_BR) begin
      o_next_pc = {i_rs_val[31:2], 2'b00};
    end else if (w_taken) begin
      o_next_pc = w_rel;
    end
  end

  assign o_misalign = (i_branch == BR_BR) && (i_rs_val[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction fetch handshake and instruction register for KGP-RISC
module instruction_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [2:0]  branch,
  input  logic        link,
  input  logic        zero,
  input  logic        sign,
  input  logic        carry,
  input  logic [31:0] rs_val,
  input  logic [25:0] pda,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        misaligned
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_halted;
  logic         r_misaligned;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;
  logic         w_misalign;
  logic         w_is_halt;
  logic         w_fetching;
  logic         w_capture;
  logic         w_retire;
  logic         w_unused_link;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_is_halt     = (r_instr[31:26] == HALT_OPCODE);
  assign w_capture     = w_fetching && imem_valid;
  assign w_retire      = (r_state == ST_EXEC) && !w_is_halt && exec_done;
  // link only steers the writeback mux downstream; the target is unaffected.
  assign w_unused_link = link;

  branch_resolver u_branch_resolver (
    .i_branch   (branch),
    .i_zero     (zero),
    .i_sign     (sign),
    .i_carry    (carry),
    .i_pc_plus4 (w_pc_plus4),
    .i_pda      (pda),
    .i_rs_val   (rs_val),
    .o_next_pc  (w_next_pc),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: w_next_state = imem_valid ? ST_EXEC : ST_WAIT;
      ST_WAIT:  if (imem_valid) w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (w_is_halt) begin
          w_next_state = ST_HALT;
        end else if (exec_done) begin
          w_next_state = ST_FETCH;
        end
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    w_fetching  = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      ST_FETCH, ST_WAIT: w_fetching  = 1'b1;
      ST_EXEC:           instr_valid = 1'b1;
      default:           ;
    endcase
  end

  // Gating with rst drops the request the moment reset asserts, not at the next edge.
  assign imem_req  = w_fetching && rst;
  assign imem_addr = r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= 32'h0000_0000;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_pc <= w_next_pc;
        if (w_misalign) begin
          r_misaligned <= 1'b1;
        end
      end
      if ((r_state == ST_EXEC) && w_is_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = r_halted;
  assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and randomized checks of instruction_fetch_unit against a transaction-level model
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic [2:0]  branch = 3'b000;
  logic        link = 1'b0;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic        carry = 1'b0;
  logic [31:0] rs_val = 32'h0;
  logic [25:0] pda = 26'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misaligned;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .HALT_OPCODE(6'b111111)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .exec_done(exec_done), .branch(branch), .link(link),
    .zero(zero), .sign(sign), .carry(carry), .rs_val(rs_val), .pda(pda),
    .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .misaligned(misaligned)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference model: one instruction at a time ----------------
  int          m_phase;   // 0 awaiting fetch, 1 executing, 2 halted
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_halted;
  logic        m_mis;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [2:0] br,
                                             input logic z, input logic s, input logic c,
                                             input logic [25:0] d, input logic [31:0] rs);
    int   disp;
    logic take;
    disp = {{6{d[25]}}, d};
    case (br)
      3'd1:    take = 1'b1;
      3'd3:    take = s;
      3'd4:    take = z;
      3'd5:    take = !z;
      3'd6:    take = c;
      3'd7:    take = !c;
      default: take = 1'b0;
    endcase
    if (br == 3'd2) return rs & 32'hFFFF_FFFC;
    if (take) return cur + 32'd4 + 32'(disp * 4);
    return cur + 32'd4;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase  <= 0;
      m_pc     <= RST_PC;
      m_instr  <= 32'h0;
      m_halted <= 1'b0;
      m_mis    <= 1'b0;
    end else if (m_phase == 0) begin
      if (imem_valid) begin
        m_instr <= imem_rdata;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (m_instr[31:26] == 6'b111111) begin
        m_phase  <= 2;
        m_halted <= 1'b1;
      end else if (exec_done) begin
        m_pc    <= model_next(m_pc, branch, zero, sign, carry, pda, rs_val);
        m_phase <= 0;
        if (branch == 3'd2 && rs_val[1:0] != 2'b00) m_mis <= 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chkb("reset_req", imem_req, 1'b0);
      chkb("reset_instr_valid", instr_valid, 1'b0);
      chk("reset_pc", pc, RST_PC);
      chk("reset_instruction", instruction, 32'h0);
      chkb("reset_halted", halted, 1'b0);
      chkb("reset_misaligned", misaligned, 1'b0);
    end else begin
      chkb("imem_req", imem_req, m_phase == 0);
      if (m_phase == 0) chk("imem_addr", imem_addr, m_pc);
      chkb("instr_valid", instr_valid, m_phase == 1);
      if (m_phase == 1) chk("instruction", instruction, m_instr);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chkb("halted", halted, m_halted);
      chkb("misaligned", misaligned, m_mis);
    end
  end

  // ---------------- instruction memory responder ----------------
  int          cfg_wait = 0;            // negative: random 0..3 wait states
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_wait = 0;
  int          halt_odds = 0;           // 1-in-N random halt words, 0 = never
  logic [31:0] word_q[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  int          acc_len[$];
  int          n_req = 0;

  initial begin : responder
    int          wcnt;
    int          len;
    logic        prev;
    logic [31:0] w;
    wcnt = 0; len = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        n_req++;
        if (!prev) begin
          len  = 0;
          wcnt = (imem_addr == slow_addr) ? slow_wait
               : (cfg_wait < 0 ? int'($urandom_range(0, 3)) : cfg_wait);
        end
        len++;
        if (wcnt == 0) begin
          if (word_q.size() > 0) begin
            w = word_q.pop_front();
          end else begin
            w = $urandom;
            if (halt_odds > 0 && $urandom_range(1, halt_odds) == 1) w[31:26] = 6'b111111;
            else if (w[31:26] == 6'b111111) w[31:26] = 6'b111110;
          end
          imem_valid = 1'b1;
          imem_rdata = w;
          acc_addr.push_back(imem_addr);
          acc_cyc.push_back(cyc);
          acc_len.push_back(len);
        end else begin
          imem_valid = 1'b0;
          imem_rdata = $urandom;
          wcnt--;
        end
      end else begin
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
      prev = imem_req;
    end
  end

  // ---------------- datapath (exec_done / branch) driver ----------------
  typedef struct {
    logic [2:0]  br;
    logic        z;
    logic        s;
    logic        c;
    logic [25:0] d;
    logic [31:0] rs;
  } br_t;

  br_t br_q[$];
  int  cfg_exec = 0;                    // negative: random 0..3 cycles until exec_done
  bit  rand_br = 1'b0;

  function automatic br_t mk_br(input logic [2:0] br, input logic z, input logic s,
                                input logic c, input logic [25:0] d, input logic [31:0] rs);
    br_t b;
    b.br = br; b.z = z; b.s = s; b.c = c; b.d = d; b.rs = rs;
    return b;
  endfunction

  function automatic br_t rnd_br();
    br_t b;
    b.br = 3'($urandom_range(0, 7));
    b.z  = 1'($urandom_range(0, 1));
    b.s  = 1'($urandom_range(0, 1));
    b.c  = 1'($urandom_range(0, 1));
    b.d  = 26'($urandom);
    b.rs = $urandom;
    if ($urandom_range(0, 7) != 0) b.rs[1:0] = 2'b00;
    return b;
  endfunction

  task automatic drive_br(input br_t b);
    branch = b.br; zero = b.z; sign = b.s; carry = b.c; pda = b.d; rs_val = b.rs;
    link   = 1'($urandom_range(0, 1));
  endtask

  initial begin : exec_drv
    int   ecnt;
    logic prev;
    br_t  b;
    ecnt = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid) begin
        if (!prev) ecnt = (cfg_exec < 0) ? int'($urandom_range(0, 3)) : cfg_exec;
        exec_done = (ecnt == 0);
        if (ecnt != 0)             b = rnd_br();
        else if (br_q.size() > 0)  b = br_q.pop_front();
        else if (rand_br)          b = rnd_br();
        else                       b = mk_br(3'd0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        drive_br(b);
        ecnt--;
      end else begin
        exec_done = 1'($urandom_range(0, 1));
        drive_br(rnd_br());
      end
      prev = instr_valid;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] acc_a(input int i);
    if (i < acc_addr.size()) return acc_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int acc_c(input int i);
    if (i < acc_cyc.size()) return acc_cyc[i];
    return -1000;
  endfunction

  function automatic int acc_l(input int i);
    if (i < acc_len.size()) return acc_len[i];
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    word_q.delete();
    br_q.delete();
    repeat (3) @(posedge clk);
    #2;
    acc_addr.delete();
    acc_cyc.delete();
    acc_len.delete();
    rst = 1'b1;
  endtask

  task automatic wait_acc(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (acc_addr.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chkb(name, acc_addr.size() >= n, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  // ---------------- directed scenarios, then randomized episodes ----------------
  initial begin : main
    int k;
    int nr;

    // zero-wait memory, immediate exec_done, no branches
    cfg_wait = 0; cfg_exec = 0; rand_br = 1'b0; halt_odds = 0;
    do_reset();
    wait_acc("seq_wait", 3, 20);
    chk("seq_addr0", acc_a(0), 32'h0);
    chk("seq_addr1", acc_a(1), 32'h4);
    chk("seq_addr2", acc_a(2), 32'h8);
    chk("seq_spacing01", 32'(acc_c(1) - acc_c(0)), 32'd2);
    chk("seq_spacing12", 32'(acc_c(2) - acc_c(1)), 32'd2);

    // three wait states at 0x10
    slow_addr = 32'h10; slow_wait = 3;
    do_reset();
    wait_acc("slow_wait", 6, 60);
    chk("slow_addr", acc_a(4), 32'h10);
    chk("slow_req_cycles", 32'(acc_l(4)), 32'd4);
    chk("fast_req_cycles", 32'(acc_l(3)), 32'd1);
    slow_addr = 32'hFFFF_FFFF;

    // bz taken / not taken with a negative displacement
    do_reset();
    br_q.push_back(mk_br(3'd2, 1'b0, 1'b0, 1'b0, 26'h0, 32'h100));
    br_q.push_back(mk_br(3'd4, 1'b1, 1'b0, 1'b0, 26'h3FFFFFE, 32'h0));
    br_q.push_back(mk_br(3'd0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0));
    br_q.push_back(mk_br(3'd4, 1'b0, 1'b0, 1'b0, 26'h3FFFFFE, 32'h0));
    wait_acc("bz_wait", 5, 40);
    chk("br_target", acc_a(1), 32'h100);
    chk("bz_taken", acc_a(2), 32'hFC);
    chk("fallthrough", acc_a(3), 32'h100);
    chk("bz_not_taken", acc_a(4), 32'h104);

    // misaligned br and bcy not taken
    do_reset();
    br_q.push_back(mk_br(3'd2, 1'b0, 1'b0, 1'b0, 26'h0, 32'h2003));
    br_q.push_back(mk_br(3'd6, 1'b0, 1'b0, 1'b0, 26'h5, 32'h0));
    wait_acc("mis_wait", 3, 30);
    chk("br_misaligned_target", acc_a(1), 32'h2000);
    chk("bcy_not_taken", acc_a(2), 32'h2004);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chkb("misaligned_sticky", misaligned, 1'b1);

    // halt opcode freezes the unit
    do_reset();
    word_q.push_back(32'h1234_5678);
    word_q.push_back(32'hFC00_0000);
    wait_acc("halt_wait", 2, 20);
    repeat (3) @(posedge clk);
    nr = n_req;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("halt_req_cycles", 32'(n_req - nr), 32'd0);
    chk("halt_pc", pc, 32'h4);
    chkb("halt_flag", halted, 1'b1);
    chkb("halt_instr_valid", instr_valid, 1'b0);

    // reset asserted while waiting on memory
    slow_addr = 32'h8; slow_wait = 6;
    do_reset();
    wait_acc("rst_wait_pre", 2, 20);
    k = 0;
    while (!(imem_req && imem_addr == 32'h8) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chkb("rst_reach_wait", imem_req && imem_addr == 32'h8, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chkb("rst_async_req", imem_req, 1'b0);
    chk("rst_async_pc", pc, RST_PC);
    slow_addr = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #2;
    acc_addr.delete(); acc_cyc.delete(); acc_len.delete();
    rst = 1'b1;
    wait_acc("rst_restart_wait", 1, 10);
    chk("rst_restart_addr", acc_a(0), RST_PC);

    // randomized episodes, some with an asynchronous reset pulse mid-run
    cfg_wait = -1; cfg_exec = -1; rand_br = 1'b1; halt_odds = 200;
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      repeat ($urandom_range(100, 400)) @(posedge clk);
      if (ep % 2 == 1) begin
        #3 rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
      end
      repeat (300) @(posedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
